// File: rtl/pr_encoder.sv
// pr_encoder: registered WIDTH-to-log2(WIDTH) priority encoder, highest set bit wins
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears y and valid
//   D      - request vector, bit i set = requester i active
//   y      - registered index of the highest set bit of D (0 when D is zero)
//   valid  - registered, 1 when the sampled D had any bit set
module pr_encoder #(
    parameter int WIDTH = 8,
    parameter int OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    output logic [OUT_W-1:0] y,
    output logic             valid
);
    // Heap-ordered binary tree: node k has children 2k and 2k+1, leaves sit at
    // WIDTH..2*WIDTH-1 and node 1 is the root, giving log2(WIDTH) mux levels.
    logic             w_v   [1:2*WIDTH-1];
    logic [OUT_W-1:0] w_idx [1:2*WIDTH-1];
    logic [OUT_W-1:0] r_y;
    logic             r_valid;
    for (genvar i = 0; i < WIDTH; i++) begin : g_leaf
        assign w_v[WIDTH+i]   = D[i];
        assign w_idx[WIDTH+i] = OUT_W'(i);
    end
    // The upper child always outranks the lower one; with no bits set the
    // choice falls through to leaf 0, so y resolves to zero.
    for (genvar k = 1; k < WIDTH; k++) begin : g_node
        assign w_v[k]   = w_v[2*k] | w_v[2*k+1];
        assign w_idx[k] = w_v[2*k+1] ? w_idx[2*k+1] : w_idx[2*k];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_valid <= 1'b0;
        end else begin
            r_y     <= w_idx[1];
            r_valid <= w_v[1];
        end
    end
    assign y     = r_y;
    assign valid = r_valid;
endmodule

// File: tb/tb_pr_encoder.sv
// tb_pr_encoder: directed self-checking bench for pr_encoder
module tb_pr_encoder;
    logic       clk;
    logic       rst_n;
    logic [7:0] D;
    logic [2:0] y;
    logic       valid;
    int         errors = 0;
    int         checks = 0;

    pr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .y     (y),
        .valid (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [2:0] ref_y(input logic [7:0] d);
        logic [2:0] r;
        r = 3'd0;
        for (int b = 0; b < 8; b++)
            if (d[b]) r = 3'(b);
        return r;
    endfunction

    task automatic check(input string tag, input logic [2:0] ey, input logic ev);
        checks++;
        assert ({y, valid} === {ey, ev}) else begin
            errors++;
            $error("FAIL %s: got y=%b valid=%b, expected y=%b valid=%b", tag, y, valid, ey, ev);
        end
    endtask

    // Called at a falling edge: apply d, then check the result one edge later.
    task automatic dc(input string tag, input logic [7:0] d, input logic [2:0] ey, input logic ev);
        D = d;
        @(negedge clk);
        check(tag, ey, ev);
    endtask

    initial begin
        rst_n = 1'b0;
        D     = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("reset_hold", 3'd0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", 3'd7, 1'b1);
        dc("onehot0", 8'h01, 3'd0, 1'b1);
        dc("onehot1", 8'h02, 3'd1, 1'b1);
        dc("onehot2", 8'h04, 3'd2, 1'b1);
        dc("onehot3", 8'h08, 3'd3, 1'b1);
        dc("onehot4", 8'h10, 3'd4, 1'b1);
        dc("onehot5", 8'h20, 3'd5, 1'b1);
        dc("onehot6", 8'h40, 3'd6, 1'b1);
        dc("onehot7", 8'h80, 3'd7, 1'b1);
        dc("prio_e0", 8'b11100000, 3'd7, 1'b1);
        dc("prio_24", 8'b00100100, 3'd5, 1'b1);
        dc("prio_03", 8'b00000011, 3'd1, 1'b1);
        dc("prio_ff", 8'hFF, 3'd7, 1'b1);
        dc("zero_pre", 8'h80, 3'd7, 1'b1);
        dc("zero", 8'h00, 3'd0, 1'b0);
        dc("async_pre", 8'h40, 3'd6, 1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_clear", 3'd0, 1'b0);
        @(posedge clk);
        #1 check("async_hold", 3'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        dc("post_reset", 8'h21, 3'd5, 1'b1);
        // A glitch on D between edges must not reach the outputs.
        D = 8'h00;
        #2 D = 8'h02;
        #1 check("mid_cycle_hold", 3'd5, 1'b1);
        @(negedge clk);
        check("mid_cycle_sample", 3'd1, 1'b1);
        for (int v = 0; v < 256; v++)
            dc($sformatf("exh_%02h", v), 8'(v), ref_y(8'(v)), v != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pr_encoder.md
# pr_encoder

Registered 8-to-3 priority encoder. Samples an 8-bit request vector every clock and reports the index of the highest-numbered set bit, plus a flag that at least one bit was set. Used wherever one of several requesters must be reduced to a binary index, such as interrupt or arbitration front-ends. Bit 7 has highest priority.

## Interface
Parameters:
- WIDTH, default 8: request vector width; must be a power of two ≥ 2.
- OUT_W, default $clog2(WIDTH) = 3: index width; derived, not overridden.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- D  input  WIDTH (8)  request vector; bit i set = requester i active.
- y  output  OUT_W (3)  registered index of the highest set bit of D.
- valid  output  1  registered; 1 when the sampled D had at least one bit set.

## Operation
- Priority: the highest index wins. y = max{ i : D[i] = 1 }. All lower set bits are ignored.
- One-hot D = 1<<i gives y = i, for i = 0..7.
- Multi-bit D:
  - 8'b11100000 gives y = 3'b111.
  - 8'b00100100 gives y = 3'b101.
- Zero input: D = 0 gives valid = 0 and y = 3'b000. The output is never X, and y is forced to 0, not held.
- valid = |D, registered alongside y.
- The encode is purely combinational from D to the register D-input. There is no internal state other than the output registers.
- X/Z on D is not supported. The block's behaviour for such inputs is not specified.

## Timing
- Latency: 1 clock. D sampled at rising edge n appears on y/valid after edge n and holds until edge n+1.
- Throughput: one new D accepted every cycle. There is no handshake and no back-pressure.
- Reset values: y = 3'b000, valid = 0.
  - Both take these values asynchronously as soon as rst_n falls, regardless of clk.
  - Both stay there while rst_n = 0.
- Reset mid-stream: outputs clear immediately. The first edge after rst_n rises samples D normally, with no extra warm-up cycle.
- D changes between edges have no effect on outputs until the next rising edge. Outputs are glitch-free because they come straight from flops.
- Combinational path from D to the flops is a single priority tree of depth log2(WIDTH). It must meet a single-cycle constraint.

## Test plan
- Reset: hold rst_n = 0 with D = 8'hFF and clk toggling -> y = 000 and valid = 0 throughout. Release reset -> the next edge gives y = 111 and valid = 1.
- One-hot sweep: D = 1<<i for i = 0..7, one per cycle -> one cycle later y = i and valid = 1 each time.
- Priority: D = 8'b11100000 -> y = 111. D = 8'b00100100 -> y = 101. D = 8'b00000011 -> y = 001. D = 8'hFF -> y = 111.
- Zero: D = 8'h00 after D = 8'h80 -> the next cycle gives y = 000 and valid = 0, with no X on outputs.
- Async reset mid-stream: D = 8'h40 registered (y = 110), then pulse rst_n low between clock edges -> y = 000 and valid = 0 immediately, with no clk edge needed.
- Exhaustive: all 256 values of D, back-to-back -> each cycle's y and valid match a reference model of the previous cycle's D.
